// File: rtl/ras_stack_param.sv
// ras_stack_param - parametrised return-address stack for the ID stage.
//
// Calls push PC+1 and returns pop it. The stack detects overflow and underflow
// (sticky flags), accepts a push and a pop in the same cycle, and keeps one
// pointer/count snapshot. That snapshot lets flush logic undo speculative
// pushes and pops.
//
// Parameters:
//   WIDTH    - entry width (PC width)
//   DEPTH    - number of entries (>= 2, any value)
//   OVF_MODE - 0: a push on full is dropped; 1: a push on full overwrites the oldest entry
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset
//   push       - push push_data this cycle
//   pop        - pop the top entry this cycle
//   push_data  - value to push
//   checkpoint - snapshot the pointer and count
//   restore    - reinstate the last snapshot (overrides push/pop/checkpoint)
//   clr_err    - clear the sticky error flags
//   top_data   - current top entry, combinational from storage; 0 when empty
//   count      - number of valid entries
//   empty      - count == 0
//   full       - count == DEPTH
//   overflow   - sticky: push with no free slot
//   underflow  - sticky: pop while empty
module ras_stack_param #(
    parameter int WIDTH    = 12,
    parameter int DEPTH    = 8,
    parameter int OVF_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       checkpoint,
    input  logic                       restore,
    input  logic                       clr_err,
    output logic [WIDTH-1:0]           top_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    tp, tpNext, topPtr, savedTp, memAddr;
    logic [CW-1:0]    countNext, savedCount;
    logic             memWe, ovfSet, udfSet;

    // DEPTH need not be a power of two, so the wrap is explicit.
    function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PW-1:0] ptrDec(input logic [PW-1:0] p);
        return (p == '0) ? PW'(DEPTH-1) : p - 1'b1;
    endfunction

    assign topPtr   = ptrDec(tp);
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign top_data = empty ? '0 : mem[topPtr];

    always_comb begin
        tpNext    = tp;
        countNext = count;
        memWe     = 1'b0;
        memAddr   = tp;
        ovfSet    = 1'b0;
        udfSet    = 1'b0;
        if (restore) begin
            tpNext    = savedTp;
            countNext = savedCount;
        end else if (push && pop) begin
            if (!empty) begin
                // Return-then-call: replace the top in place.
                memWe   = 1'b1;
                memAddr = topPtr;
            end else begin
                // Nothing to pop. DEPTH >= 2, so an empty stack always has room.
                memWe     = 1'b1;
                tpNext    = ptrInc(tp);
                countNext = count + 1'b1;
                udfSet    = 1'b1;
            end
        end else if (push) begin
            if (!full) begin
                memWe     = 1'b1;
                tpNext    = ptrInc(tp);
                countNext = count + 1'b1;
            end else begin
                ovfSet = 1'b1;
                if (OVF_MODE != 0) begin
                    // When full, tp points at the oldest entry. It is overwritten here.
                    memWe  = 1'b1;
                    tpNext = ptrInc(tp);
                end
            end
        end else if (pop) begin
            if (!empty) begin
                tpNext    = topPtr;
                countNext = count - 1'b1;
            end else begin
                udfSet = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[memAddr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tp         <= '0;
            count      <= '0;
            savedTp    <= '0;
            savedCount <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            tp        <= tpNext;
            count     <= countNext;
            // A new error event in the same cycle as clr_err leaves the flag set.
            overflow  <= ovfSet | (overflow & ~clr_err);
            underflow <= udfSet | (underflow & ~clr_err);
            if (checkpoint && !restore) begin
                savedTp    <= tp;
                savedCount <= count;
            end
        end
    end

endmodule

// File: doc/ras_stack_param.md
Name: ras_stack_param

Overview:
- Parametrised hardware return-address stack; replaces the fixed stack in the pipelined CPU's ID stage.
- ID pushes PC+1 on call and pops on return. Depth, width and overflow policy are configurable.
- New over the fixed stack: overflow/underflow detection, simultaneous push+pop, and a checkpoint/restore pair.
- Checkpoint/restore lets the hazard/flush logic undo speculative pushes and pops on a branch flush.

Parameters:
WIDTH, 12, data width of each entry (PC width).
DEPTH, 8, number of entries; ≥2, need not be a power of two.
OVF_MODE, 0, 0 = push on full is dropped and flagged; 1 = push on full overwrites the oldest entry (circular) and is flagged.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
push  in  1  push push_data this cycle.
pop  in  1  pop top entry this cycle.
push_data  in  WIDTH  value to push.
checkpoint  in  1  snapshot pointer and count.
restore  in  1  reinstate last snapshot.
clr_err  in  1  clear sticky error flags.
top_data  out  WIDTH  current top entry, combinational from storage; 0 when empty.
count  out  clog2(DEPTH+1)  valid entries.
empty  out  1  count==0.
full  out  1  count==DEPTH.
overflow  out  1  sticky: push with no free slot.
underflow  out  1  sticky: pop while empty.

Behaviour:
- Storage: DEPTH×WIDTH registers, not reset.
- Write pointer tp (clog2(DEPTH) bits) points to the next free slot. Top = mem[tp-1 mod DEPTH].
- All pointer arithmetic wraps modulo DEPTH, explicitly: DEPTH-1 → 0 and 0 → DEPTH-1.
- Reset (rst low, async): tp=0, count=0, saved_tp=0, saved_count=0, overflow=0, underflow=0. Outputs: top_data=0, empty=1, full=0.
- Per-edge priority (highest first):
  1. restore=1: tp<=saved_tp, count<=saved_count. push, pop and checkpoint are ignored that cycle. Entry contents are not restored.
  2. push & pop, count>0: mem[tp-1]<=push_data; tp and count unchanged (return-then-call).
  3. push & pop, count==0: treated as push only; underflow<=1.
  4. push only, count<DEPTH: mem[tp]<=push_data, tp++, count++.
  5. push only, count==DEPTH:
     - overflow<=1 in both modes.
     - OVF_MODE=0: no state change.
     - OVF_MODE=1: mem[tp]<=push_data, tp++ (the oldest entry is lost), count stays DEPTH.
  6. pop only, count>0: tp--, count--.
  7. pop only, count==0: no state change; underflow<=1.
- checkpoint=1 without restore: saved_tp/saved_count capture the pre-edge tp/count, even when a push/pop happens in the same cycle.
- Pop timing: the popped value is top_data in the cycle pop is asserted (zero latency). The stack updates at that edge.
- Sticky flags:
  - clr_err clears both flags.
  - If clr_err coincides with a new error event, the flag ends set (set wins).
- Flags are unaffected by restore.
- count, empty and full reflect registered state only; no combinational path from push/pop to these outputs.

Test Plan:
- DEPTH=4: after reset, push 0x010,0x020,0x030 → count=3, top_data=0x030; pop ×3 → top_data reads 0x030,0x020,0x010 in the pop cycles; empty=1.
- OVF_MODE=0, DEPTH=4: push 1,2,3,4,5 → full=1, overflow=1, top_data=4; pop ×4 → 4,3,2,1.
- OVF_MODE=1, DEPTH=4: push 1..6 → count=4, overflow=1; pops return 6,5,4,3, then empty=1.
- Push 0x0AA, then push & pop together with push_data=0x0BB → count=1, top_data=0x0BB. On an empty stack, push & pop with 0x0CC → count=1, top_data=0x0CC, underflow=1.
- Checkpoint with count=2 and top 0x020 in the same cycle as a push of 0x030; then pop ×2; then restore → count=2, top_data=0x020. Restore asserted together with a push → push ignored.
- Pop on empty → underflow=1 and stays set. clr_err coinciding with another empty pop → underflow remains 1. clr_err alone → 0. Asserting rst low mid-sequence, between edges, immediately gives count=0, empty=1, top_data=0.
